// File: rtl/axi_stream_downsizing_if.sv
// -----------------------------------------------------------------------------
// axi_stream_downsizing_if
// Purpose : AXI-Stream beat bundle, sized by a width code EW
//           (data = 8<<EW bits, keep = 1<<EW bits).
// Signals : tvalid, tready, tdata, tkeep, tlast
// Modports: master - produces beats (drives tvalid/tdata/tkeep/tlast)
//           slave  - consumes beats (drives tready)
// -----------------------------------------------------------------------------
interface axi_stream_downsizing_if #(
   parameter int EW = 0
);
   logic                  tvalid;
   logic                  tready;
   logic [(8 << EW)-1:0]  tdata;
   logic [(1 << EW)-1:0]  tkeep;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axi_stream_downsizing.sv
// -----------------------------------------------------------------------------
// axi_stream_downsizing
// Purpose : Splits each wide AXI-Stream beat (8<<IEW bits) into up to
//           R = 1<<(IEW-OEW) narrow beats (8<<OEW bits). Sub-beats whose keep
//           slice is all-zero are skipped. A beat with all-zero keep and tlast
//           set is forwarded as a single null beat (keep 0, last 1). A beat
//           with all-zero keep and no tlast is dropped.
// Ports   : clk    - clock, rising edge
//           rstn   - asynchronous active-low reset
//           s_axis - wide input stream  (slave modport,  EW = IEW)
//           m_axis - narrow output stream (master modport, EW = OEW), registered
// -----------------------------------------------------------------------------
module axi_stream_downsizing #(
   parameter int IEW = 2,
   parameter int OEW = 0
) (
   input  logic                            clk,
   input  logic                            rstn,
   axi_stream_downsizing_if.slave          s_axis,
   axi_stream_downsizing_if.master         m_axis
);

   localparam int R  = 1 << (IEW - OEW);
   localparam int IW = 8 << IEW;
   localparam int OW = 8 << OEW;
   localparam int IK = 1 << IEW;
   localparam int OK = 1 << OEW;
   localparam int SW = IEW - OEW;

   // Wide buffer. buf_keep_reg holds only the keep bits still waiting to be
   // emitted; buf_null_reg marks a null-last beat (sub-beat 0 pending, keep 0).
   logic             buf_full_reg;
   logic             buf_last_reg;
   logic             buf_null_reg;
   logic [IW-1:0]    buf_data_reg;
   logic [IK-1:0]    buf_keep_reg;

   logic             o_tvalid_reg;
   logic [OW-1:0]    o_tdata_reg;
   logic [OK-1:0]    o_tkeep_reg;
   logic             o_tlast_reg;

   logic [OW-1:0]    slice_data [R];
   logic [OK-1:0]    slice_keep [R];
   logic [R-1:0]     sub_pend;
   logic [R-1:0]     sel_onehot;
   logic [IK-1:0]    clr_mask;
   logic [SW-1:0]    sel;
   logic             last_pend;
   logic             slot_free;
   logic             emit;
   logic             in_ready;
   logic             in_hs;

   generate
      for (genvar gi = 0; gi < R; gi++) begin : g_slice
         assign slice_data[gi]            = buf_data_reg[gi*OW +: OW];
         assign slice_keep[gi]            = buf_keep_reg[gi*OK +: OK];
         assign sub_pend[gi]              = |slice_keep[gi];
         assign sel_onehot[gi]            = (sel == SW'(gi));
         assign clr_mask[gi*OK +: OK]     = {OK{sel_onehot[gi]}};
      end
   endgenerate

   // Lowest-index pending sub-beat wins; scanning downwards lets the lowest
   // index overwrite. A null-last beat has nothing pending and falls to 0.
   always_comb begin
      sel = '0;
      for (int k = R - 1; k >= 0; k--) begin
         if (sub_pend[k]) begin
            sel = SW'(k);
         end
      end
   end

   assign last_pend = ((sub_pend & ~sel_onehot) == '0);
   assign slot_free = m_axis.tready | ~o_tvalid_reg;
   assign emit      = buf_full_reg & slot_free;

   // Accept a new beat while the final sub-beat leaves, so back-to-back
   // input produces no output bubble.
   assign in_ready  = ~buf_full_reg | (emit & last_pend);
   assign in_hs     = s_axis.tvalid & in_ready;

   assign s_axis.tready = in_ready;
   assign m_axis.tvalid = o_tvalid_reg;
   assign m_axis.tdata  = o_tdata_reg;
   assign m_axis.tkeep  = o_tkeep_reg;
   assign m_axis.tlast  = o_tlast_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_full_reg <= 1'b0;
         buf_last_reg <= 1'b0;
         buf_null_reg <= 1'b0;
         buf_data_reg <= '0;
         buf_keep_reg <= '0;
         o_tvalid_reg <= 1'b0;
         o_tdata_reg  <= '0;
         o_tkeep_reg  <= '0;
         o_tlast_reg  <= 1'b0;
      end else begin
         if (emit) begin
            o_tvalid_reg <= 1'b1;
            o_tdata_reg  <= slice_data[sel];
            o_tkeep_reg  <= slice_keep[sel];
            o_tlast_reg  <= last_pend & buf_last_reg;
            buf_keep_reg <= buf_keep_reg & ~clr_mask;
            if (last_pend) begin
               buf_full_reg <= 1'b0;
               buf_null_reg <= 1'b0;
            end
         end else if (m_axis.tready) begin
            o_tvalid_reg <= 1'b0;
         end

         // A load overrides the emptying done by the emit above.
         if (in_hs) begin
            if (|s_axis.tkeep) begin
               buf_full_reg <= 1'b1;
               buf_null_reg <= 1'b0;
               buf_data_reg <= s_axis.tdata;
               buf_keep_reg <= s_axis.tkeep;
               buf_last_reg <= s_axis.tlast;
            end else if (s_axis.tlast) begin
               buf_full_reg <= 1'b1;
               buf_null_reg <= 1'b1;
               buf_data_reg <= s_axis.tdata;
               buf_keep_reg <= '0;
               buf_last_reg <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_downsizing.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_downsizing
// Purpose : Self-checking bench for axi_stream_downsizing (IEW=2, OEW=0).
//           Directed beats plus randomized traffic; a reference model turns
//           every accepted input beat into its expected list of byte beats.
// -----------------------------------------------------------------------------
module tb_axi_stream_downsizing;

   typedef struct packed {
      logic [7:0] d;
      logic       k;
      logic       l;
   } beat_t;

   logic clk;
   logic rstn;

   axi_stream_downsizing_if #(.EW(2)) s_if ();
   axi_stream_downsizing_if #(.EW(0)) m_if ();

   axi_stream_downsizing #(.IEW(2), .OEW(0)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .s_axis (s_if),
      .m_axis (m_if)
   );

   int    checks    = 0;
   int    failures  = 0;
   int    out_count = 0;
   beat_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: each set keep bit is one output byte, in ascending
   // byte order; tlast rides on the highest kept byte. Empty keep with last
   // becomes one null beat carrying byte 0; empty keep without last vanishes.
   task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
      int hi;
      beat_t b;
      hi = -1;
      for (int j = 0; j < 4; j++) if (k[j]) hi = j;
      if (k == 4'h0) begin
         if (l) begin
            b.d = d[7:0]; b.k = 1'b0; b.l = 1'b1;
            exp_q.push_back(b);
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (k[j]) begin
               b.d = d[8*j +: 8]; b.k = 1'b1; b.l = l && (j == hi);
               exp_q.push_back(b);
            end
         end
      end
   endtask

   // Monitor: samples on the falling edge, scoring output handshakes,
   // checking stall stability and feeding accepted inputs to the model.
   initial begin
      bit         prev_stall;
      logic [9:0] prev_vec;
      beat_t      e;
      prev_stall = 1'b0;
      prev_vec   = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", {31'b0, m_if.tvalid}, 32'd1);
               chk("hold_beat", {22'b0, m_if.tdata, m_if.tkeep, m_if.tlast}, {22'b0, prev_vec});
            end
            if (m_if.tvalid && m_if.tready) begin
               out_count++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_beat", {22'b0, m_if.tdata, m_if.tkeep, m_if.tlast}, {22'b0, e.d, e.k, e.l});
               end
            end
            if (s_if.tvalid && s_if.tready)
               model_push(s_if.tdata, s_if.tkeep, s_if.tlast);
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_vec   = {m_if.tdata, m_if.tkeep, m_if.tlast};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input bit rr);
      bit ok;
      ok = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      for (int c = 0; c < 100 && !ok; c++) begin
         if (rr) m_if.tready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         ok = s_if.tready;
         tick();
      end
      s_if.tvalid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      m_if.tready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         tick();
         done = (exp_q.size() == 0) && !m_if.tvalid;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic       v_at [16];
      logic [7:0] d_at [16];
      int         stage;
      int         first;
      int         c0;
      bit         hs;
      logic [31:0] rd;
      logic [3:0]  rk;
      logic        rl;

      rstn        = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_tvalid", {31'b0, m_if.tvalid}, 32'd0);
      chk("rst_tdata",  {24'b0, m_if.tdata},  32'd0);
      chk("rst_tkeep",  {31'b0, m_if.tkeep},  32'd0);
      chk("rst_tlast",  {31'b0, m_if.tlast},  32'd0);
      rstn = 1'b1;
      tick();
      chk("rel_itready", {31'b0, s_if.tready}, 32'd1);
      m_if.tready = 1'b1;

      // Full beat: four bytes on consecutive cycles
      send(32'h44332211, 4'hF, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("full_tvalid", {31'b0, m_if.tvalid}, 32'd1);
         chk("full_tdata",  {24'b0, m_if.tdata}, 32'h11 * (j + 1));
         chk("full_tlast",  {31'b0, m_if.tlast}, (j == 3) ? 32'd1 : 32'd0);
      end
      tick();
      chk("full_idle_tvalid", {31'b0, m_if.tvalid}, 32'd0);
      drain();

      // Sparse beat: keep 0x5
      send(32'hDDCCBBAA, 4'h5, 1'b1, 1'b0);
      tick();
      chk("sparse_b0", {22'b0, m_if.tdata, m_if.tkeep, m_if.tlast}, {22'b0, 8'hAA, 1'b1, 1'b0});
      tick();
      chk("sparse_b1", {22'b0, m_if.tdata, m_if.tkeep, m_if.tlast}, {22'b0, 8'hCC, 1'b1, 1'b1});
      drain();

      // Null-last beat: one beat, keep 0, last 1
      c0 = out_count;
      send(32'h12345678, 4'h0, 1'b1, 1'b0);
      tick();
      chk("nulllast_beat", {29'b0, m_if.tvalid, m_if.tkeep, m_if.tlast}, {29'b0, 1'b1, 1'b0, 1'b1});
      drain();
      chk("nulllast_count", out_count - c0, 32'd1);

      // Null non-last beat: dropped, ready stays high
      c0 = out_count;
      send(32'hDEADBEEF, 4'h0, 1'b0, 1'b0);
      chk("null_itready", {31'b0, s_if.tready}, 32'd1);
      repeat (4) tick();
      chk("null_count", out_count - c0, 32'd0);
      chk("null_tvalid", {31'b0, m_if.tvalid}, 32'd0);

      // Backpressure after the second byte
      send(32'h44332211, 4'hF, 1'b1, 1'b0);
      tick();
      tick();
      chk("bp_second", {24'b0, m_if.tdata}, 32'h22);
      m_if.tready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("bp_hold_tdata", {24'b0, m_if.tdata}, 32'h22);
         chk("bp_itready",    {31'b0, s_if.tready}, 32'd0);
      end
      drain();

      // Back-to-back full beats
      stage = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h44332211;
      s_if.tkeep  = 4'hF;
      s_if.tlast  = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         v_at[cyc] = m_if.tvalid;
         d_at[cyc] = m_if.tdata;
         hs = s_if.tvalid && s_if.tready;
         if (hs && stage == 1)
            chk("b2b_ready_at_44", {23'b0, m_if.tvalid, m_if.tdata}, {23'b0, 1'b1, 8'h33});
         tick();
         if (hs) begin
            stage++;
            if (stage == 1) s_if.tdata = 32'h88776655;
            else s_if.tvalid = 1'b0;
         end
      end
      s_if.tvalid = 1'b0;
      chk("b2b_both_taken", stage, 32'd2);
      first = 16;
      for (int cyc = 15; cyc >= 0; cyc--) if (v_at[cyc]) first = cyc;
      for (int j = 0; j < 8; j++) begin
         if (first + j < 16) begin
            chk("b2b_tvalid", {31'b0, v_at[first + j]}, 32'd1);
            chk("b2b_tdata",  {24'b0, d_at[first + j]}, 32'h11 * (j + 1));
         end else begin
            chk("b2b_window", 32'd0, 32'd1);
         end
      end
      drain();

      // Asynchronous reset while 0x33 is pending
      send(32'h44332211, 4'hF, 1'b1, 1'b0);
      tick();
      tick();
      #1 rstn = 1'b0;
      #1;
      chk("arst_outputs", {22'b0, m_if.tvalid, m_if.tdata, m_if.tkeep}, 32'd0);
      chk("arst_tlast",   {31'b0, m_if.tlast}, 32'd0);
      chk("arst_itready", {31'b0, s_if.tready}, 32'd1);
      exp_q.delete();
      tick();
      rstn = 1'b1;
      tick();
      chk("arst_rel_itready", {31'b0, s_if.tready}, 32'd1);
      send(32'h00000099, 4'h1, 1'b1, 1'b0);
      tick();
      chk("arst_next_beat", {21'b0, m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast},
          {21'b0, 1'b1, 8'h99, 1'b1, 1'b1});
      drain();

      // Randomized traffic with random backpressure
      for (int n = 0; n < 60; n++) begin
         rd = $urandom;
         rk = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) rk = 4'h0;
         rl = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) begin
            m_if.tready = ($urandom_range(0, 3) != 0);
            tick();
         end
         send(rd, rk, rl, 1'b1);
      end
      drain();
      chk("rand_queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
